// File: rtl/debug_pkg.sv
// Shared definitions for the single-step / free-run debug clock-enable controller.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_RUN_DIV         = 50000000;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debug_step_ctrl_btn_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits one press pulse per accepted button press.
module btn_debounce
  import debug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_btn_raw,
  output logic       o_press,
  output logic [1:0] o_state
);

  localparam int unsigned CW           = cnt_width(DEBOUNCE_CYCLES);
  // The IDLE sample that leaves IDLE is the first of the stable 1s, so WAIT_PRESS needs one fewer.
  localparam int unsigned PRESS_LAST   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam int unsigned RELEASE_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

  logic          r_sync1;
  logic          r_sync2;
  btn_state_e    r_state;
  btn_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (r_sync2) w_state_next = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (!r_sync2) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt >= CW'(PRESS_LAST)) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        w_state_next = ST_WAIT_RELEASE;
        w_cnt_next   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (r_sync2) begin
          w_cnt_next = '0;
        end else if (r_cnt >= CW'(RELEASE_LAST)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_press = (r_state == ST_PRESSED);
  assign o_state = r_state;

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug clock-enable generator: debounced single-step or divided free-run CpuEn, with pulse counter.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnStep,
  input  logic        RunMode,
  input  logic        Halt,
  output logic        CpuEn,
  output logic [15:0] StepCount,
  output logic [1:0]  BtnState
);

  localparam int unsigned DW = cnt_width(RUN_DIV - 1);

  logic          w_press;
  logic [1:0]    w_btn_state;
  logic          r_mode_sync1;
  logic          r_mode_sync2;
  logic          r_mode_q;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_next;
  logic          r_cpu_en;
  logic          w_cpu_en_next;
  logic [15:0]   r_step_count;
  logic          w_mode_change;
  logic          w_div_wrap;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_btn_raw(BtnStep),
    .o_press  (w_press),
    .o_state  (w_btn_state)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode_sync1 <= 1'b0;
      r_mode_sync2 <= 1'b0;
      r_mode_q     <= 1'b0;
      r_div        <= '0;
      r_cpu_en     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_mode_sync1 <= RunMode;
      r_mode_sync2 <= r_mode_sync1;
      r_mode_q     <= r_mode_sync2;
      r_div        <= w_div_next;
      r_cpu_en     <= w_cpu_en_next;
      r_step_count <= r_step_count + 16'(r_cpu_en);
    end
  end

  assign w_mode_change = (r_mode_sync2 != r_mode_q);
  assign w_div_wrap    = (r_div == DW'(RUN_DIV - 1));

  // A mode switch restarts the divider and swallows anything that would fire in that cycle.
  always_comb begin
    w_div_next    = r_div;
    w_cpu_en_next = 1'b0;
    if (w_mode_change) begin
      w_div_next = '0;
    end else if (r_mode_q) begin
      if (!Halt) begin
        if (w_div_wrap) begin
          w_div_next    = '0;
          w_cpu_en_next = !r_cpu_en;
        end else begin
          w_div_next = r_div + DW'(1);
        end
      end
    end else begin
      w_div_next    = '0;
      w_cpu_en_next = w_press && !Halt && !r_cpu_en;
    end
  end

  assign CpuEn     = r_cpu_en;
  assign StepCount = r_step_count;
  assign BtnState  = w_btn_state;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scenario bench for debug_step_ctrl with a cycle-count reference model (DEBOUNCE_CYCLES=4, RUN_DIV=5).
module tb_debug_step_ctrl;

  localparam int D = 4;
  localparam int R = 5;

  logic        clk;
  logic        rst;
  logic        btn;
  logic        run_mode;
  logic        halt;
  logic        cpu_en;
  logic [15:0] step_count;
  logic [1:0]  btn_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_count  = '0;

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (R)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .BtnStep  (btn),
    .RunMode  (run_mode),
    .Halt     (halt),
    .CpuEn    (cpu_en),
    .StepCount(step_count),
    .BtnState (btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // One clock: inputs set before the call are sampled at the posedge; outputs are read at the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; run_mode = 1'b0; halt = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL reset cpu_en: got %0b expected 0", cpu_en); end
    n_checks++;
    if (step_count !== 16'h0) begin n_errors++; $display("FAIL reset step_count: got %h expected 0000", step_count); end
    n_checks++;
    if (btn_state !== 2'd0) begin n_errors++; $display("FAIL reset btn_state: got %0d expected 0", btn_state); end
    rst = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (cpu_en !== 1'b0 || btn_state !== 2'd0) begin
      n_errors++; $display("FAIL post_reset idle: cpu_en=%0b state=%0d expected 0/0", cpu_en, btn_state);
    end
    m_count = '0;
  endtask

  task automatic wait_release(input string name);
    btn = 1'b0;
    for (int k = 1; k <= D + 6; k++) begin
      tick();
      n_checks++;
      if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL %s release cpu_en cycle %0d: got %0b expected 0", name, k, cpu_en); end
    end
    n_checks++;
    if (btn_state !== 2'd0) begin n_errors++; $display("FAIL %s released state: got %0d expected 0", name, btn_state); end
  endtask

  task automatic test_clean_press();
    logic exp_en;
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_en = (k == D + 3);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL clean_press cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL clean_press step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
      if (k == 3) begin
        n_checks++;
        if (btn_state !== 2'd1) begin n_errors++; $display("FAIL clean_press wait_press state: got %0d expected 1", btn_state); end
      end
      if (k == D + 2) begin
        n_checks++;
        if (btn_state !== 2'd2) begin n_errors++; $display("FAIL clean_press pressed state: got %0d expected 2", btn_state); end
      end
      if (k == 20) begin
        n_checks++;
        if (btn_state !== 2'd3) begin n_errors++; $display("FAIL clean_press held state: got %0d expected 3", btn_state); end
      end
    end
    n_checks++;
    if (step_count !== 16'd1) begin n_errors++; $display("FAIL clean_press final count: got %0d expected 1", step_count); end
    wait_release("clean_press");
  endtask

  task automatic test_bounce_press();
    logic [4:0] pat;
    logic exp_en;
    pat = 5'b01101;  // driven LSB first: 1,0,1,1,0
    for (int j = 0; j < 5; j++) begin
      btn = pat[j];
      tick();
      n_checks++;
      if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL bounce prefix cpu_en step %0d: got %0b expected 0", j, cpu_en); end
    end
    btn = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_en = (k == 7);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL bounce cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL bounce step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
    end
    wait_release("bounce");
  endtask

  task automatic test_halt_on_press();
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL halt_press cpu_en cycle %0d: got %0b expected 0", k, cpu_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL halt_press step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (k == 8) begin
        n_checks++;
        if (btn_state !== 2'd3) begin n_errors++; $display("FAIL halt_press state: got %0d expected 3", btn_state); end
      end
      halt = (k == D + 2) || (k == D + 3);
    end
    halt = 1'b0;
    wait_release("halt_press");
  endtask

  task automatic test_run_mode();
    int   n;
    int   pulses;
    int   first_pulse;
    logic h;
    logic exp_en;
    halt = 1'b0;
    run_mode = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL run_enter cpu_en cycle %0d: got %0b expected 0", k, cpu_en); end
    end
    n = 0;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n++;
      exp_en = (n % R == 0);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL run_free cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL run_free step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
      if (cpu_en === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 6) begin n_errors++; $display("FAIL run_free pulse_count: got %0d expected 6", pulses); end
    first_pulse = 0;
    for (int k = 1; k <= 12; k++) begin
      h = (k <= 3);
      halt = h;
      tick();
      if (!h) n++;
      exp_en = !h && (n % R == 0);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL run_halt cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      if (exp_en) m_count++;
      if (cpu_en === 1'b1 && first_pulse == 0) first_pulse = k;
    end
    n_checks++;
    if (first_pulse != R + 3) begin n_errors++; $display("FAIL run_halt delay: pulse at %0d expected %0d", first_pulse, R + 3); end
    for (int k = 1; k <= 80; k++) begin
      h = ($urandom_range(0, 3) == 0);
      halt = h;
      btn = (k > 74) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (!h) n++;
      exp_en = !h && (n % R == 0);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL run_random cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL run_random step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
    end
    halt = 1'b0;
    run_mode = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) n++;
      exp_en = (k < 3) && (n % R == 0);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL run_exit cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      if (exp_en) m_count++;
    end
    wait_release("run_exit");
    n_checks++;
    if (step_count !== m_count) begin n_errors++; $display("FAIL run_exit step_count: got %h expected %h", step_count, m_count); end
  endtask

  task automatic test_random_presses();
    logic seq[$];
    int   p;
    int   pulse_at;
    int   nruns;
    logic exp_en;
    for (int ev = 0; ev < 6; ev++) begin
      seq.delete();
      nruns = $urandom_range(0, 3);
      for (int r = 0; r < nruns; r++) begin
        repeat ($urandom_range(1, D - 1)) seq.push_back(1'b1);
        repeat ($urandom_range(1, 2)) seq.push_back(1'b0);
      end
      p = seq.size();
      repeat ($urandom_range(D, 16)) seq.push_back(1'b1);
      repeat (D + 6) seq.push_back(1'b0);
      pulse_at = p + D + 3;
      for (int i = 0; i < seq.size(); i++) begin
        btn = seq[i];
        tick();
        exp_en = (i + 1 == pulse_at);
        n_checks++;
        if (cpu_en !== exp_en) begin n_errors++; $display("FAIL rand_press ev %0d cpu_en cycle %0d: got %0b expected %0b", ev, i + 1, cpu_en, exp_en); end
        n_checks++;
        if (step_count !== m_count) begin n_errors++; $display("FAIL rand_press ev %0d step_count: got %h expected %h", ev, step_count, m_count); end
        if (exp_en) m_count++;
      end
      n_checks++;
      if (btn_state !== 2'd0) begin n_errors++; $display("FAIL rand_press ev %0d end state: got %0d expected 0", ev, btn_state); end
    end
  endtask

  task automatic test_step_count_wrap();
    int   n;
    logic exp_en;
    force dut.r_step_count = 16'hFFFD;
    #1;
    release dut.r_step_count;
    m_count = 16'hFFFD;
    run_mode = 1'b1;
    repeat (3) tick();
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n++;
      exp_en = (n % R == 0);
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL wrap step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
    end
    n_checks++;
    if (step_count !== 16'h0000) begin n_errors++; $display("FAIL wrap final: got %h expected 0000", step_count); end
    run_mode = 1'b0;
    repeat (3) tick();
    repeat (R) tick();
    n_checks++;
    if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL wrap exit cpu_en: got %0b expected 0", cpu_en); end
  endtask

  task automatic test_reset_mid_press();
    logic exp_en;
    btn = 1'b1;
    repeat (D + 1) tick();
    n_checks++;
    if (btn_state !== 2'd1) begin n_errors++; $display("FAIL mid_reset pre state: got %0d expected 1", btn_state); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (cpu_en !== 1'b0 || step_count !== 16'h0 || btn_state !== 2'd0) begin
      n_errors++; $display("FAIL mid_reset async: cpu_en=%0b count=%h state=%0d expected all 0", cpu_en, step_count, btn_state);
    end
    m_count = '0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_en = (k == D + 3);
      n_checks++;
      if (cpu_en !== exp_en) begin n_errors++; $display("FAIL mid_reset cpu_en cycle %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      n_checks++;
      if (step_count !== m_count) begin n_errors++; $display("FAIL mid_reset step_count cycle %0d: got %h expected %h", k, step_count, m_count); end
      if (exp_en) m_count++;
    end
    wait_release("mid_reset");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_halt_on_press();
    test_run_mode();
    test_random_presses();
    test_step_count_wrap();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_step_ctrl.md
DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter: RUN_DIV, 50000000, Clk cycles between CpuEn pulses in run mode (minimum 2).
REQ-003 Port: Clk  input  1  single system clock; every flop is on its rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: BtnStep  input  1  raw, bouncy, asynchronous step push-button.
REQ-006 Port: RunMode  input  1  raw asynchronous switch; 1 = free-run, 0 = single-step.
REQ-007 Port: Halt  input  1  synchronous; 1 suppresses all CpuEn pulses.
REQ-008 Port: CpuEn  output  1  one-cycle clock-enable pulse advancing the pipeline by one cycle.
REQ-009 Port: StepCount  output  16  number of CpuEn pulses issued since reset, shown on the 7-segment display.
REQ-010 Port: BtnState  output  2  current debounce FSM state, for display/debug.

Function
REQ-011 BtnStep and RunMode SHALL each pass through a two-flop synchronizer before use.
REQ-012 Debounce FSM states SHALL be IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3.
REQ-013 IDLE -> WAIT_PRESS when synchronized button = 1; the counter clears.
REQ-014 WAIT_PRESS: counter increments on each synchronized 1; any 0 returns to IDLE with the counter cleared; at DEBOUNCE_CYCLES consecutive 1s -> PRESSED.
REQ-015 PRESSED SHALL last exactly one cycle, raise an internal step request, then go to WAIT_RELEASE with the counter cleared.
REQ-016 WAIT_RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive synchronized 0s; any 1 clears the counter.
REQ-017 A held button SHALL produce exactly one step request per press, whatever the hold time.
REQ-018 Single-step mode: CpuEn = 1 for exactly the cycle after PRESSED, unless Halt = 1 in that cycle, in which case the request is dropped and not queued.
REQ-019 Single-step latency: with a clean press, CpuEn SHALL be high in cycle DEBOUNCE_CYCLES+3, counting the first edge that samples BtnStep = 1 as cycle 1.
REQ-020 Run mode: a divider SHALL count 0..RUN_DIV-1, and CpuEn pulses for one cycle when the count wraps to 0, unless Halt = 1.
REQ-021 Halt SHALL freeze the run divider at its current value and SHALL NOT clear it.
REQ-022 On any change of synchronized RunMode, the divider SHALL clear to 0; no CpuEn SHALL occur in the switching cycle.
REQ-023 In run mode, step requests SHALL be discarded, while the debounce FSM keeps running.
REQ-024 CpuEn SHALL never be high for two consecutive cycles.
REQ-025 StepCount SHALL increment by 1 in the cycle after each CpuEn pulse and wrap from 0xFFFF to 0x0000.
REQ-026 CpuEn and BtnState SHALL be registered outputs with no combinational path from any input.

Reset
REQ-027 Reset SHALL asynchronously force: FSM = IDLE, debounce counter = 0, divider = 0, both synchronizers = 0, CpuEn = 0, StepCount = 0, BtnState = 0.
REQ-028 Reset asserted mid-press SHALL drop the pending step; after release, a held button SHALL re-debounce from IDLE and produce one pulse.

Structure
REQ-029 A shared package debug_pkg SHALL hold the FSM state encoding and the default DEBOUNCE_CYCLES and RUN_DIV constants.
REQ-030 The synchronizer and debounce FSM SHALL be a sub-module btn_debounce, outputting a one-cycle press pulse and the state; the mode, divider and counter logic stay in debug_step_ctrl.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=5)
REQ-031 Clean press held 20 cycles, RunMode=0 -> CpuEn high only in cycle 7, StepCount=1.
REQ-032 Bouncing press 1,0,1,1,0 then steady 1 -> exactly one CpuEn, 7 cycles after the start of the steady 1s.
REQ-033 RunMode=1 for 30 cycles -> CpuEn every 5th cycle, 6 pulses, never adjacent; Halt=1 for 3 cycles delays the next pulse by exactly 3.
REQ-034 Preload StepCount via 65535 run pulses, then one more pulse -> StepCount=0x0000.
REQ-035 Reset asserted in WAIT_PRESS cycle 3 -> all outputs 0 immediately; no CpuEn until a new press completes its full debounce.
REQ-036 Press completes with Halt=1 in the PRESSED+1 cycle -> no CpuEn, StepCount unchanged, FSM in WAIT_RELEASE.
